// File: rtl/alu_issue_ctrl_if.sv
// Issue-side bus of the ALU sequencer: instruction handshake, register-file
// read/write ports, ALU operand/control/result lines, PSR and branch outputs.
// The slave modport is the sequencer; the master modport is its environment
// (fetch/decode, register file and ALU).
interface alu_issue_ctrl_if #(
    parameter int RF_AW = 4
);
    logic             instr_valid;
    logic [15:0]      instr;
    logic [15:0]      pc;
    logic             instr_ready;

    logic [RF_AW-1:0] rf_raddr_a;
    logic [RF_AW-1:0] rf_raddr_b;
    logic [15:0]      rf_rdata_a;
    logic [15:0]      rf_rdata_b;

    logic [15:0]      alu_a;
    logic [15:0]      alu_b;
    logic [15:0]      alu_pc;
    logic [3:0]       alu_op_code;
    logic [3:0]       alu_ext_code;
    logic             alu_imm_mode;
    logic             alu_carry_in;
    logic             alu_is_branch;
    logic [15:0]      alu_result;
    logic             alu_c;
    logic             alu_l;
    logic             alu_f;
    logic             alu_z;
    logic             alu_n;

    logic             rf_we;
    logic [RF_AW-1:0] rf_waddr;
    logic [15:0]      rf_wdata;

    logic [4:0]       psr;
    logic             branch_taken;
    logic [15:0]      branch_target;
    logic             done;

    modport slave (
        input  instr_valid, instr, pc,
        input  rf_rdata_a, rf_rdata_b,
        input  alu_result, alu_c, alu_l, alu_f, alu_z, alu_n,
        output instr_ready,
        output rf_raddr_a, rf_raddr_b,
        output alu_a, alu_b, alu_pc, alu_op_code, alu_ext_code,
        output alu_imm_mode, alu_carry_in, alu_is_branch,
        output rf_we, rf_waddr, rf_wdata,
        output psr, branch_taken, branch_target, done
    );

    modport master (
        output instr_valid, instr, pc,
        output rf_rdata_a, rf_rdata_b,
        output alu_result, alu_c, alu_l, alu_f, alu_z, alu_n,
        input  instr_ready,
        input  rf_raddr_a, rf_raddr_b,
        input  alu_a, alu_b, alu_pc, alu_op_code, alu_ext_code,
        input  alu_imm_mode, alu_carry_in, alu_is_branch,
        input  rf_we, rf_waddr, rf_wdata,
        input  psr, branch_taken, branch_target, done
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: multi-cycle sequencer owning the ALU.
// Accepts one instruction per handshake (IDLE only), reads Rdest/Rsrc from the
// register file, drives the ALU, writes back the result, maintains the PSR
// {C,L,F,Z,N} and evaluates Bcond.
// Optional macro ALU_OUT_REG_EN: adds an EXEC2 state that registers the ALU
// outputs in EXEC and commits them in EXEC2 (accept->done latency 4 instead of 3).
module alu_issue_ctrl #(
    parameter int RF_AW = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    alu_issue_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_EXEC2,
        S_WB
    } state_t;

    state_t           r_state;
    logic [15:0]      r_instr;
    logic [15:0]      r_pc;
    logic             r_ready;
    logic [RF_AW-1:0] r_raddr_a;
    logic [RF_AW-1:0] r_raddr_b;
    logic [RF_AW-1:0] r_waddr;
    logic [4:0]       r_psr;
    logic             r_we;
    logic             r_done;
    logic             r_taken;
    logic [15:0]      r_wdata;
    logic [15:0]      r_target;

    logic [3:0]       w_op;
    logic [3:0]       w_ext;
    logic [3:0]       w_cond;
    logic             w_cfz;
    logic             w_lnz;
    logic             w_zonly;
    logic             w_nflag;
    logic             w_wb;
    logic             w_br;
    logic             w_cond_met;
    logic             w_commit;
    logic             w_take;
    logic [15:0]      w_res;
    logic [4:0]       w_flg;
    logic [4:0]       w_psr_nxt;
    logic             w_in_exec;

`ifdef ALU_OUT_REG_EN
    logic [15:0]      r_res;
    logic [4:0]       r_flg;
    logic             r_cond;
`endif

    assign w_op      = r_instr[15:12];
    assign w_cond    = r_instr[11:8];
    assign w_ext     = r_instr[7:4];
    assign w_in_exec = (r_state == S_EXEC);

    // Classify the latched instruction by which PSR bits it may update and whether it writes back
    always_comb begin
        w_cfz   = ((w_op == 4'h0) && (w_ext inside {4'h5, 4'h7, 4'h9, 4'hA}))
                || (w_op inside {4'h5, 4'h9});
        w_lnz   = ((w_op == 4'h0) && (w_ext == 4'hB)) || (w_op == 4'hB);
        w_zonly = ((w_op == 4'h0) && (w_ext inside {4'h1, 4'h2, 4'h3, 4'h4, 4'hD}))
                || (w_op inside {4'h1, 4'h2, 4'h3, 4'h8, 4'hF});
        w_nflag = ((w_op == 4'h0) && (w_ext == 4'h6)) || (w_op == 4'h6);
        w_wb    = w_cfz || w_zonly || w_nflag;
        w_br    = (w_op == 4'hC);
    end

    // Branch condition evaluated against the PSR as held during EXEC
    always_comb begin
        w_cond_met = 1'b0;
        case (w_cond)
            4'h0:    w_cond_met =  r_psr[1];
            4'h1:    w_cond_met = ~r_psr[1];
            4'h2:    w_cond_met =  r_psr[3];
            4'h3:    w_cond_met = ~r_psr[3];
            4'h4:    w_cond_met =  r_psr[0];
            4'h5:    w_cond_met = ~r_psr[0];
            4'h6:    w_cond_met =  r_psr[2];
            4'h7:    w_cond_met = ~r_psr[2];
            4'hE:    w_cond_met = 1'b1;
            default: w_cond_met = 1'b0;
        endcase
    end

    // Select the commit point and the result/flag source feeding it
    always_comb begin
`ifdef ALU_OUT_REG_EN
        w_commit = (r_state == S_EXEC2);
        w_res    = r_res;
        w_flg    = r_flg;
        w_take   = r_cond;
`else
        w_commit = w_in_exec;
        w_res    = bus.alu_result;
        w_flg    = {bus.alu_c, bus.alu_l, bus.alu_f, bus.alu_z, bus.alu_n};
        w_take   = w_cond_met;
`endif
    end

    // Merge ALU flags into the PSR under the per-instruction mask
    always_comb begin
        w_psr_nxt = r_psr;
        if (w_cfz) begin
            w_psr_nxt[4] = w_flg[4];
            w_psr_nxt[2] = w_flg[2];
            w_psr_nxt[1] = w_flg[1];
        end
        if (w_lnz) begin
            w_psr_nxt[3] = w_flg[3];
            w_psr_nxt[1] = w_flg[1];
            w_psr_nxt[0] = w_flg[0];
        end
        if (w_zonly) begin
            w_psr_nxt[1] = w_flg[1];
        end
    end

    // Sequencer FSM with registered handshake, writeback, PSR and branch outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_instr   <= '0;
            r_pc      <= '0;
            r_ready   <= 1'b0;
            r_raddr_a <= '0;
            r_raddr_b <= '0;
            r_waddr   <= '0;
            r_psr     <= '0;
            r_we      <= 1'b0;
            r_done    <= 1'b0;
            r_taken   <= 1'b0;
            r_wdata   <= '0;
            r_target  <= '0;
`ifdef ALU_OUT_REG_EN
            r_res     <= '0;
            r_flg     <= '0;
            r_cond    <= 1'b0;
`endif
        end else begin
            r_we    <= 1'b0;
            r_done  <= 1'b0;
            r_taken <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_ready && bus.instr_valid) begin
                        r_instr   <= bus.instr;
                        r_pc      <= bus.pc;
                        r_raddr_a <= RF_AW'(bus.instr[11:8]);
                        r_raddr_b <= RF_AW'(bus.instr[3:0]);
                        r_ready   <= 1'b0;
                        r_state   <= S_READ;
                    end else begin
                        r_ready   <= 1'b1;
                    end
                end
                S_READ: r_state <= S_EXEC;
                S_EXEC: begin
`ifdef ALU_OUT_REG_EN
                    r_res   <= bus.alu_result;
                    r_flg   <= {bus.alu_c, bus.alu_l, bus.alu_f, bus.alu_z, bus.alu_n};
                    r_cond  <= w_cond_met;
                    r_state <= S_EXEC2;
`else
                    r_state <= S_WB;
`endif
                end
                S_EXEC2: r_state <= S_WB;
                S_WB: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_commit) begin
                r_done  <= 1'b1;
                r_wdata <= w_res;
                r_waddr <= RF_AW'(w_cond);
                r_we    <= w_wb;
                r_psr   <= w_psr_nxt;
                r_taken <= w_br && w_take;
                if (w_br) begin
                    r_target <= w_res;
                end
            end
        end
    end

    assign bus.instr_ready   = r_ready;
    assign bus.rf_raddr_a    = r_raddr_a;
    assign bus.rf_raddr_b    = r_raddr_b;
    assign bus.alu_a         = w_in_exec ? bus.rf_rdata_a : '0;
    assign bus.alu_b         = !w_in_exec        ? '0 :
                               (w_op == 4'h0)    ? bus.rf_rdata_b :
                                                   {8'h00, r_instr[7:0]};
    assign bus.alu_pc        = r_pc;
    assign bus.alu_op_code   = w_op;
    assign bus.alu_ext_code  = w_ext;
    assign bus.alu_imm_mode  = (w_op != 4'h0);
    assign bus.alu_carry_in  = r_psr[4];
    assign bus.alu_is_branch = w_br;
    assign bus.rf_we         = r_we;
    assign bus.rf_waddr      = r_waddr;
    assign bus.rf_wdata      = r_wdata;
    assign bus.psr           = r_psr;
    assign bus.branch_taken  = r_taken;
    assign bus.branch_target = r_target;
    assign bus.done          = r_done;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: behavioural register file and ALU around the
// sequencer, directed spec scenarios followed by random instructions checked
// against an instruction-level reference model.
module tb_alu_issue_ctrl;

`ifdef ALU_OUT_REG_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    alu_issue_ctrl_if #(.RF_AW(4)) bus ();

    alu_issue_ctrl #(.RF_AW(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // ALU function: returns {result, C, L, F, Z, N}
    function automatic logic [20:0] alu_fn(input logic [3:0] op, input logic [3:0] ext,
                                           input logic [15:0] a, input logic [15:0] b,
                                           input logic cin, input logic [15:0] p);
        logic [3:0]  fc;
        logic [16:0] w;
        logic [15:0] r;
        logic        c;
        logic        f;
        fc = (op == 4'h0) ? ext : op;
        w = '0; r = '0; c = 1'b0; f = 1'b0;
        case (fc)
            4'h1: r = a & b;
            4'h2: r = a | b;
            4'h3: r = a ^ b;
            4'h4, 4'h8: r = b[7] ? (a >> b[3:0]) : (a << b[3:0]);
            4'h5, 4'h6, 4'h7: begin
                w = {1'b0, a} + {1'b0, b} + 17'((fc == 4'h7) & cin);
                r = w[15:0];
                c = w[16];
                f = (a[15] == b[15]) && (r[15] != a[15]);
            end
            4'h9, 4'hA, 4'hB: begin
                w = {1'b0, a} - {1'b0, b} - 17'((fc == 4'hA) & cin);
                r = w[15:0];
                c = w[16];
                f = (a[15] != b[15]) && (r[15] != a[15]);
            end
            4'hC: r = p + {{8{b[7]}}, b[7:0]};
            4'hD: r = b;
            4'hF: r = {b[7:0], a[7:0]};
            default: r = '0;
        endcase
        return {r, c, (a < b), f, (r == 16'h0), ($signed(a) < $signed(b))};
    endfunction

    assign {bus.alu_result, bus.alu_c, bus.alu_l, bus.alu_f, bus.alu_z, bus.alu_n} =
        alu_fn(bus.alu_op_code, bus.alu_ext_code, bus.alu_a, bus.alu_b, bus.alu_carry_in, bus.alu_pc);

    // Register file environment with registered reads and a preload port
    logic [15:0] rf [16];
    logic        pre_we = 1'b0;
    logic [3:0]  pre_addr = '0;
    logic [15:0] pre_data = '0;
    always @(posedge clk) begin
        bus.rf_rdata_a <= rf[bus.rf_raddr_a];
        bus.rf_rdata_b <= rf[bus.rf_raddr_b];
        if (bus.rf_we)   rf[bus.rf_waddr] <= bus.rf_wdata;
        else if (pre_we) rf[pre_addr]     <= pre_data;
    end

    // Reference architectural state
    logic [15:0] mreg [16];
    logic [4:0]  mpsr = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [3:0] ad, input logic [15:0] d);
        pre_we = 1'b1; pre_addr = ad; pre_data = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
        mreg[ad] = d;
    endtask

    function automatic logic cond_ok(input logic [3:0] cnd, input logic [4:0] ps);
        case (cnd)
            4'h0: return ps[1];
            4'h1: return !ps[1];
            4'h2: return ps[3];
            4'h3: return !ps[3];
            4'h4: return ps[0];
            4'h5: return !ps[0];
            4'h6: return ps[2];
            4'h7: return !ps[2];
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Issue one instruction, check every cycle up to retirement, then update the model
    task automatic issue(input logic [15:0] ins, input logic [15:0] p);
        logic [3:0]  op, ext, rd, rs;
        logic [15:0] a, b, r;
        logic        c, l, f, z, n;
        logic        cfz, lnz, zo, nf, wb, br, tk;
        logic [4:0]  ep;
        int          waits;
        op = ins[15:12]; rd = ins[11:8]; ext = ins[7:4]; rs = ins[3:0];
        a  = mreg[rd];
        b  = (op == 4'h0) ? mreg[rs] : {8'h00, ins[7:0]};
        {r, c, l, f, z, n} = alu_fn(op, ext, a, b, mpsr[4], p);
        cfz = ((op == 4'h0) && (ext inside {4'h5, 4'h7, 4'h9, 4'hA})) || (op inside {4'h5, 4'h9});
        lnz = ((op == 4'h0) && (ext == 4'hB)) || (op == 4'hB);
        zo  = ((op == 4'h0) && (ext inside {4'h1, 4'h2, 4'h3, 4'h4, 4'hD})) || (op inside {4'h1, 4'h2, 4'h3, 4'h8, 4'hF});
        nf  = ((op == 4'h0) && (ext == 4'h6)) || (op == 4'h6);
        wb  = cfz || zo || nf;
        br  = (op == 4'hC);
        tk  = br && cond_ok(rd, mpsr);
        ep  = mpsr;
        if (cfz) begin ep[4] = c; ep[2] = f; ep[1] = z; end
        if (lnz) begin ep[3] = l; ep[1] = z; ep[0] = n; end
        if (zo)  ep[1] = z;

        waits = 0;
        while (bus.instr_ready !== 1'b1 && waits < 20) begin
            @(posedge clk); #1; waits++;
        end
        chk("ready_before_issue", 32'(bus.instr_ready), 32'd1);
        bus.instr_valid = 1'b1; bus.instr = ins; bus.pc = p;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0; bus.instr = 16'($urandom); bus.pc = 16'($urandom);

        for (int k = 1; k <= LAT; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            chk("ready_busy", 32'(bus.instr_ready), 32'd0);
            if (k == 1) begin
                chk("raddr_a", 32'(bus.rf_raddr_a), 32'(rd));
                chk("raddr_b", 32'(bus.rf_raddr_b), 32'(rs));
            end
            if (k == 2) begin
                chk("carry_in", 32'(bus.alu_carry_in), 32'(mpsr[4]));
                chk("imm_mode", 32'(bus.alu_imm_mode), 32'(op != 4'h0));
                chk("is_branch", 32'(bus.alu_is_branch), 32'(br));
                chk("alu_pc", 32'(bus.alu_pc), 32'(p));
            end
            if (k < LAT) begin
                chk("done_early", 32'(bus.done), 32'd0);
                chk("we_early", 32'(bus.rf_we), 32'd0);
            end else begin
                chk("done", 32'(bus.done), 32'd1);
                chk("rf_we", 32'(bus.rf_we), 32'(wb));
                if (wb) begin
                    chk("rf_waddr", 32'(bus.rf_waddr), 32'(rd));
                    chk("rf_wdata", 32'(bus.rf_wdata), 32'(r));
                end
                chk("branch_taken", 32'(bus.branch_taken), 32'(tk));
                if (br) chk("branch_target", 32'(bus.branch_target), 32'(r));
                chk("psr_wb", 32'(bus.psr), 32'(ep));
            end
        end
        @(posedge clk); #1;
        chk("done_pulse", 32'(bus.done), 32'd0);
        chk("psr_after", 32'(bus.psr), 32'(ep));
        chk("ready_after", 32'(bus.instr_ready), 32'd1);
        mpsr = ep;
        if (wb) mreg[rd] = r;
    endtask

    initial begin
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        bus.pc          = '0;
        for (int i = 0; i < 16; i++) begin
            rf[i]   = '0;
            mreg[i] = '0;
        end

        // Reset state
        #3 reset_n = 1'b0;
        #10;
        chk("rst_psr", 32'(bus.psr), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_we", 32'(bus.rf_we), 32'd0);
        chk("rst_ready", 32'(bus.instr_ready), 32'd0);
        chk("rst_taken", 32'(bus.branch_taken), 32'd0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", 32'(bus.instr_ready), 32'd1);

        // ADD R1,R2 : 5+3
        preload(4'd1, 16'd5); preload(4'd2, 16'd3);
        issue(16'h0152, 16'h0010);
        chk("add_r1", 32'(rf[1]), 32'd8);
        chk("add_cfz", 32'({bus.psr[4], bus.psr[2], bus.psr[1]}), 32'd0);

        // ADD FFFF+1 then ADDC R3,R4 with carry set
        preload(4'd1, 16'hFFFF); preload(4'd2, 16'h0001);
        issue(16'h0152, 16'h0012);
        chk("add_wrap_r1", 32'(rf[1]), 32'd0);
        chk("add_wrap_c", 32'(bus.psr[4]), 32'd1);
        chk("add_wrap_z", 32'(bus.psr[1]), 32'd1);
        preload(4'd3, 16'h0000); preload(4'd4, 16'h0000);
        issue(16'h0374, 16'h0014);
        chk("addc_r3", 32'(rf[3]), 32'd1);

        // CMP R1,R2 : 2 vs 5
        preload(4'd1, 16'd2); preload(4'd2, 16'd5);
        issue(16'h01B2, 16'h0016);
        chk("cmp_lnz", 32'({bus.psr[3], bus.psr[1], bus.psr[0]}), 32'b101);
        chk("cmp_r1_kept", 32'(rf[1]), 32'd2);

        // Bcond EQ/NE after forcing Z=1 with ANDI R5,#0
        issue(16'h1500, 16'h0018);
        issue(16'hC0FE, 16'h0040);
        issue(16'hC1FE, 16'h0040);

        // Undefined opcode / extension: done only
        issue(16'h4123, 16'h0020);
        issue(16'h0F12, 16'h0022);

        // Reset during EXEC of ADDI R6,#3
        preload(4'd6, 16'd7);
        bus.instr_valid = 1'b1; bus.instr = 16'h5603; bus.pc = 16'h0030;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #2;
        chk("abort_psr", 32'(bus.psr), 32'd0);
        chk("abort_we", 32'(bus.rf_we), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_ready", 32'(bus.instr_ready), 32'd1);
        chk("abort_r6_kept", 32'(rf[6]), 32'd7);
        mpsr = '0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("abort_no_we", 32'(bus.rf_we), 32'd0);
        end

        // Random instructions over random register contents
        for (int i = 0; i < 16; i++) preload(4'(i), 16'($urandom));
        for (int i = 0; i < 80; i++) begin
            logic [15:0] ri;
            ri = 16'($urandom);
            if (i % 4 == 0) ri[15:12] = 4'h0;
            issue(ri, 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
